// File: rtl/vend_coin_sequencer.sv
// Coin capture, ordered buffering and one-coin-per-slot issue to the vending FSM,
// followed by dispense and change handshakes after each sale.
module vend_coin_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 3
) (
  input  logic          i_clk,
  input  logic          reset,
  input  logic          i_coin_nickle,
  input  logic          i_coin_dime,
  input  logic          i_coin_quarter,
  output logic          o_vm_nickle,
  output logic          o_vm_dime,
  output logic          o_vm_quarter,
  input  logic          i_vm_soda,
  input  logic [2:0]    i_vm_change,
  output logic          o_dispense,
  input  logic          i_dispense_done,
  output logic          o_change_req,
  output logic [2:0]    o_change_nickels,
  input  logic          i_change_done,
  output logic          o_coin_reject,
  output logic [2:0]    o_reject_type,
  output logic [CW-1:0] o_fifo_count,
  output logic          o_busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DISPENSE, S_CHANGE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      coin, pend, pend_nxt, grant, rej;
  logic [1:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            push, pop;
  logic [1:0]      push_code;
  logic [2:0]      chg_lat, chg_nxt, vm_nxt;

  function automatic logic [2:0] clamp_change(input logic [2:0] c);
    return (c > 3'd4) ? 3'd4 : c;
  endfunction

  function automatic logic [2:0] code_to_strobe(input logic [1:0] code);
    case (code)
      2'b01:   return 3'b001;
      2'b10:   return 3'b010;
      2'b11:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Capture and arbitration: the full check uses the occupancy before any same-cycle pop
  always_comb begin
    coin  = {i_coin_quarter, i_coin_dime, i_coin_nickle};
    grant = 3'b000;
    if (count < CW'(FIFO_DEPTH)) begin
      if (pend[0])      grant = 3'b001;
      else if (pend[1]) grant = 3'b010;
      else if (pend[2]) grant = 3'b100;
    end
    push      = |grant;
    push_code = grant[0] ? 2'b01 : (grant[1] ? 2'b10 : 2'b11);
    rej       = coin & pend & ~grant;
    pend_nxt  = (pend & ~grant) | coin;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    chg_nxt   = chg_lat;
    vm_nxt    = 3'b000;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          vm_nxt    = code_to_strobe(fifo_mem[rd_ptr]);
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_vm_soda) begin
          chg_nxt   = clamp_change(i_vm_change);
          state_nxt = S_DISPENSE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_DISPENSE: begin
        if (i_dispense_done) state_nxt = (chg_lat != 3'd0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        if (i_change_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= push_code;
    chg_lat <= chg_nxt;
  end

  // Registered control and outputs
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state            <= S_IDLE;
      pend             <= 3'b000;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      o_vm_nickle      <= 1'b0;
      o_vm_dime        <= 1'b0;
      o_vm_quarter     <= 1'b0;
      o_dispense       <= 1'b0;
      o_change_req     <= 1'b0;
      o_change_nickels <= 3'd0;
      o_coin_reject    <= 1'b0;
      o_reject_type    <= 3'b000;
      o_busy           <= 1'b0;
    end else begin
      state            <= state_nxt;
      pend             <= pend_nxt;
      count            <= count_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      o_vm_nickle      <= vm_nxt[0];
      o_vm_dime        <= vm_nxt[1];
      o_vm_quarter     <= vm_nxt[2];
      o_dispense       <= (state_nxt == S_DISPENSE);
      o_change_req     <= (state_nxt == S_CHANGE);
      o_change_nickels <= (state_nxt == S_CHANGE) ? chg_nxt : 3'd0;
      o_coin_reject    <= |rej;
      o_reject_type    <= rej;
      o_busy           <= (|pend_nxt) | (count_nxt != '0) | (state_nxt != S_IDLE);
    end
  end

  assign o_fifo_count = count;

endmodule

// File: tb/tb_vend_coin_sequencer.sv
// Bench for vend_coin_sequencer: cycle table for the idle dime case, hand sequences
// for multi-coin, FIFO-full, stalled handshake, clamp and reset cases.
module tb_vend_coin_sequencer;

  logic       i_clk = 1'b0;
  logic       reset;
  logic       i_coin_nickle, i_coin_dime, i_coin_quarter;
  logic       o_vm_nickle, o_vm_dime, o_vm_quarter;
  logic       i_vm_soda;
  logic [2:0] i_vm_change;
  logic       o_dispense, i_dispense_done;
  logic       o_change_req;
  logic [2:0] o_change_nickels;
  logic       i_change_done;
  logic       o_coin_reject;
  logic [2:0] o_reject_type;
  logic [2:0] o_fifo_count;
  logic       o_busy;

  vend_coin_sequencer #(.FIFO_DEPTH(4), .CW(3)) dut (
    .i_clk(i_clk), .reset(reset),
    .i_coin_nickle(i_coin_nickle), .i_coin_dime(i_coin_dime), .i_coin_quarter(i_coin_quarter),
    .o_vm_nickle(o_vm_nickle), .o_vm_dime(o_vm_dime), .o_vm_quarter(o_vm_quarter),
    .i_vm_soda(i_vm_soda), .i_vm_change(i_vm_change),
    .o_dispense(o_dispense), .i_dispense_done(i_dispense_done),
    .o_change_req(o_change_req), .o_change_nickels(o_change_nickels),
    .i_change_done(i_change_done),
    .o_coin_reject(o_coin_reject), .o_reject_type(o_reject_type),
    .o_fifo_count(o_fifo_count), .o_busy(o_busy)
  );

  initial forever #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [2:0]  coin;  // {quarter, dime, nickle}
    logic        soda;
    logic [2:0]  chg;
    logic        ddone;
    logic        cdone;
    logic [15:0] exp;   // {vm[2:0], disp, creq, nick[2:0], rej, rtype[2:0], cnt[2:0], busy}
  } vec_t;

  vec_t       tbl [19];
  logic [2:0] sb_q [$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;

  function automatic vec_t mk(input logic [2:0] coin, input logic soda, input logic [2:0] chg,
                              input logic dd, input logic cd, input logic [2:0] vm,
                              input logic disp, input logic creq, input logic [2:0] nick,
                              input logic [2:0] cnt, input logic busy);
    vec_t v;
    v.coin = coin; v.soda = soda; v.chg = chg; v.ddone = dd; v.cdone = cd;
    v.exp  = {vm, disp, creq, nick, 1'b0, 3'b000, cnt, busy};
    return v;
  endfunction

  function automatic logic [15:0] outs();
    return {o_vm_quarter, o_vm_dime, o_vm_nickle, o_dispense, o_change_req, o_change_nickels,
            o_coin_reject, o_reject_type, o_fifo_count, o_busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Advance one clock; any coin strobe is compared against the scoreboard head
  task automatic step();
    logic [2:0] vm, req;
    @(posedge i_clk);
    #1;
    cyc++;
    vm = {o_vm_quarter, o_vm_dime, o_vm_nickle};
    if (vm != 3'b000) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_strobe: got %b, expected no strobe (cycle %0d)", vm, cyc);
      end else begin
        req = sb_q.pop_front();
        if (vm !== req) begin
          n_fail++;
          $display("FAIL sb_strobe: got %b, expected %b (cycle %0d)", vm, req, cyc);
        end
      end
    end
  endtask

  task automatic wait_vm(input int budget, output int t);
    int i;
    t = -1;
    i = 0;
    while (t < 0 && i < budget) begin
      step();
      if ({o_vm_quarter, o_vm_dime, o_vm_nickle} != 3'b000) t = cyc;
      i++;
    end
    if (t < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_vm: got no strobe, expected one within %0d cycles", budget);
    end
  endtask

  task automatic coins(input logic [2:0] c);
    {i_coin_quarter, i_coin_dime, i_coin_nickle} = c;
  endtask

  initial begin
    int t0, t, prev, bad;
    logic rej_seen;
    reset = 1'b1;
    coins(3'b000);
    i_vm_soda = 1'b0; i_vm_change = 3'd0; i_dispense_done = 1'b0; i_change_done = 1'b0;
    step(); step();
    reset = 1'b0;

    // Single dime, idle, second dime 10 cycles later and sold with no change
    tbl[0]  = mk(3'b010, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
    tbl[2]  = mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1);
    tbl[3]  = mk(3'b000, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 1);
    tbl[4]  = mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
    tbl[5]  = mk(3'b000, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0);
    tbl[6]  = mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    tbl[7]  = mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    tbl[8]  = mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    tbl[9]  = mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    tbl[10] = mk(3'b010, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    tbl[11] = mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
    tbl[12] = mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1);
    tbl[13] = mk(3'b000, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 1);
    tbl[14] = mk(3'b000, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
    tbl[15] = mk(3'b000, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 1);
    tbl[16] = mk(3'b000, 0, 0, 1, 0, 3'b000, 1, 0, 0, 0, 1);
    tbl[17] = mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    tbl[18] = mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    for (int i = 0; i < 19; i++) begin
      chk($sformatf("tbl_row%0d", i), 32'(outs()), 32'(tbl[i].exp));
      coins(tbl[i].coin);
      if (tbl[i].coin != 3'b000) sb_q.push_back(tbl[i].coin);
      i_vm_soda = tbl[i].soda; i_vm_change = tbl[i].chg;
      i_dispense_done = tbl[i].ddone; i_change_done = tbl[i].cdone;
      step();
    end
    coins(3'b000); i_vm_soda = 0; i_dispense_done = 0; i_change_done = 0;

    // All three coins together: nickle, dime, quarter, 3 cycles apart; sale with 4 change
    t0 = cyc;
    coins(3'b111);
    sb_q.push_back(3'b001); sb_q.push_back(3'b010); sb_q.push_back(3'b100);
    step(); coins(3'b000);
    wait_vm(10, t); chk("multi_nickle_time", 32'(t - t0), 32'd3);
    wait_vm(10, t); chk("multi_dime_time", 32'(t - t0), 32'd6);
    wait_vm(10, t); chk("multi_quarter_time", 32'(t - t0), 32'd9);
    step(); i_vm_soda = 1; i_vm_change = 3'd4;
    step(); i_vm_soda = 0; i_vm_change = 3'd0;
    chk("multi_dispense", 32'(o_dispense), 32'd1);
    i_dispense_done = 1; step(); i_dispense_done = 0;
    chk("multi_change", 32'({o_dispense, o_change_req, o_change_nickels}), 32'({1'b0, 1'b1, 3'd4}));
    i_change_done = 1; step(); i_change_done = 0;
    chk("multi_change_end", 32'({o_change_req, o_change_nickels, o_busy}), 32'd0);
    step(); step();

    // Quarter sale with dispense stalled; FIFO filled by repeated dimes, then nickle overflow
    coins(3'b100); sb_q.push_back(3'b100); step(); coins(3'b000);
    wait_vm(10, t);
    step(); i_vm_soda = 1; i_vm_change = 3'd1;
    step(); i_vm_soda = 0; i_vm_change = 3'd0;
    chk("stall_dispense_start", 32'(o_dispense), 32'd1);
    rej_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      coins(3'b010); sb_q.push_back(3'b010); step();
      rej_seen |= o_coin_reject;
    end
    coins(3'b000); step();
    rej_seen |= o_coin_reject;
    chk("redrive_while_draining", 32'(rej_seen), 32'd0);
    chk("fifo_full_count", 32'(o_fifo_count), 32'd4);
    coins(3'b001); sb_q.push_back(3'b001); step();
    chk("first_nickle_held", 32'(o_coin_reject), 32'd0);
    coins(3'b001); step(); coins(3'b000);
    chk("overflow_reject", 32'({o_coin_reject, o_reject_type}), 32'({1'b1, 3'b001}));
    chk("overflow_count", 32'(o_fifo_count), 32'd4);
    step();
    chk("reject_one_cycle", 32'({o_coin_reject, o_reject_type}), 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!o_dispense || ({o_vm_quarter, o_vm_dime, o_vm_nickle} != 3'b000)) bad++;
    end
    chk("stall_held", 32'(bad), 32'd0);
    i_dispense_done = 1; step(); i_dispense_done = 0;
    chk("stall_change", 32'({o_dispense, o_change_req, o_change_nickels}), 32'({1'b0, 1'b1, 3'd1}));
    i_change_done = 1; step(); i_change_done = 0;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_vm(10, t);
      if (i > 0) chk($sformatf("drain_spacing%0d", i), 32'(t - prev), 32'd3);
      prev = t;
    end
    step(); step();
    chk("drain_idle_busy", 32'({o_busy, o_fifo_count}), 32'd0);

    // Change value above 4 is clamped
    coins(3'b001); sb_q.push_back(3'b001); step(); coins(3'b000);
    wait_vm(10, t);
    step(); i_vm_soda = 1; i_vm_change = 3'd6;
    step(); i_vm_soda = 0; i_vm_change = 3'd0;
    i_dispense_done = 1; step(); i_dispense_done = 0;
    chk("clamp_change6", 32'({o_change_req, o_change_nickels}), 32'({1'b1, 3'd4}));
    i_change_done = 1; step(); i_change_done = 0;
    step(); step();

    // Reset during CHANGE with two coins queued
    coins(3'b100); sb_q.push_back(3'b100); step(); coins(3'b000);
    wait_vm(10, t);
    step(); i_vm_soda = 1; i_vm_change = 3'd2;
    step(); i_vm_soda = 0; i_vm_change = 3'd0;
    coins(3'b011); step(); coins(3'b000);
    step(); step();
    i_dispense_done = 1; step(); i_dispense_done = 0;
    step();
    chk("pre_reset_change", 32'({o_change_req, o_change_nickels, o_fifo_count}),
        32'({1'b1, 3'd2, 3'd2}));
    reset = 1; step(); reset = 0;
    chk("reset_outputs", 32'(outs()), 32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("post_reset_idle", 32'(outs()), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
